// File: rtl/pe_sequencer.sv
// pe_sequencer: drives a single PE through one 1D-convolution pass.
// It stages the weights and activations, bursts them into the PE without
// bubbles, leaves one idle cycle so the PE spad addresses rewind, and pulses
// start. It then waits for pe_done and issues the sum phase. Returned psums
// are collected in a 2-entry output FIFO with valid/ready handshaking.
module pe_sequencer #(
  parameter int dataSize      = 8,
  parameter int rfNumRegister = 16,
  parameter int macResSize    = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            cfg_wcount,
  input  logic [7:0]            cfg_acount,
  input  logic                  cfg_reuse_w,
  input  logic                  cfg_first_row,
  input  logic                  go,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [dataSize-1:0]   w_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [dataSize-1:0]   a_data,
  input  logic                  psin_valid,
  output logic                  psin_ready,
  input  logic [macResSize-1:0] psin_data,
  output logic [dataSize-1:0]   pe_weights,
  output logic [dataSize-1:0]   pe_acts,
  output logic [macResSize-1:0] pe_psum,
  output logic                  pe_loadw,
  output logic                  pe_loada,
  output logic                  pe_start,
  output logic                  pe_sums,
  input  logic [macResSize-1:0] pe_psum_o,
  input  logic                  pe_psum_valid,
  input  logic                  pe_done,
  output logic                  psout_valid,
  input  logic                  psout_ready,
  output logic [macResSize-1:0] psout_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int CW = $clog2(rfNumRegister + 1);
  localparam int AW = $clog2(rfNumRegister);

  typedef enum logic [2:0] {
    S_IDLE, S_STAGE, S_BURST, S_GAP, S_START, S_COMPUTE, S_SUMS, S_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   wcount_q, acount_q, ocount_q;
  logic [CW-1:0]   wcnt_q, acnt_q, k_q, issued_q, captured_q;
  logic            reuse_q, first_row_q, cfg_err_q;
  logic [dataSize-1:0]   stage_w_q [rfNumRegister];
  logic [dataSize-1:0]   stage_a_q [rfNumRegister];
  logic [macResSize-1:0] fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      fifo_cnt_q;

  logic          cfg_ok, w_fire, a_fire, w_all, a_all, push, pop, room;
  logic [CW-1:0] weff, inflight;

  // Pass configuration check: 1 <= wcount <= acount <= depth.
  assign cfg_ok = (cfg_wcount != 8'd0) && (cfg_acount >= cfg_wcount) &&
                  (cfg_acount <= 8'(rfNumRegister));

  assign w_ready = (state_q == S_STAGE) && !reuse_q && (wcnt_q < wcount_q);
  assign a_ready = (state_q == S_STAGE) && (acnt_q < acount_q);
  assign w_fire  = w_valid && w_ready;
  assign a_fire  = a_valid && a_ready;
  assign w_all   = reuse_q || ((wcnt_q + CW'(w_fire)) == wcount_q);
  assign a_all   = (acnt_q + CW'(a_fire)) == acount_q;

  // Reused weights are not reloaded, so the weight burst is empty.
  assign weff       = reuse_q ? '0 : wcount_q;
  assign pe_loadw   = (state_q == S_BURST) && (k_q < weff);
  assign pe_loada   = (state_q == S_BURST);
  assign pe_weights = pe_loadw ? stage_w_q[k_q[AW-1:0]] : '0;
  assign pe_acts    = pe_loada ? stage_a_q[k_q[AW-1:0]] : '0;
  assign pe_start   = (state_q == S_START);

  // An issue is allowed only when a FIFO slot is guaranteed for its result.
  assign inflight   = issued_q - captured_q;
  assign room       = (CW'(fifo_cnt_q) + inflight) < CW'(2);
  assign pe_sums    = (state_q == S_SUMS) && (issued_q < ocount_q) &&
                      (first_row_q || psin_valid) && room;
  assign psin_ready = pe_sums && !first_row_q;
  assign pe_psum    = psin_ready ? psin_data : '0;

  assign push        = (state_q == S_SUMS) && pe_psum_valid;
  assign pop         = psout_valid && psout_ready;
  assign psout_valid = (fifo_cnt_q != 2'd0);
  assign psout_data  = psout_valid ? fifo_q[rd_ptr_q] : '0;

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign cfg_err = cfg_err_q;

  // Main pass sequencer with staging, burst and sum-phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcount_q    <= '0;
      acount_q    <= '0;
      ocount_q    <= '0;
      wcnt_q      <= '0;
      acnt_q      <= '0;
      k_q         <= '0;
      issued_q    <= '0;
      captured_q  <= '0;
      reuse_q     <= 1'b0;
      first_row_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (cfg_ok) begin
              wcount_q    <= cfg_wcount[CW-1:0];
              acount_q    <= cfg_acount[CW-1:0];
              ocount_q    <= cfg_acount[CW-1:0] - cfg_wcount[CW-1:0] + CW'(1);
              reuse_q     <= cfg_reuse_w;
              first_row_q <= cfg_first_row;
              wcnt_q      <= '0;
              acnt_q      <= '0;
              state_q     <= S_STAGE;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_STAGE: begin
          if (w_fire) wcnt_q <= wcnt_q + CW'(1);
          if (a_fire) acnt_q <= acnt_q + CW'(1);
          if (w_all && a_all) begin
            k_q     <= '0;
            state_q <= S_BURST;
          end
        end
        S_BURST: begin
          k_q <= k_q + CW'(1);
          if (k_q == acount_q - CW'(1)) state_q <= S_GAP;
        end
        S_GAP:   state_q <= S_START;
        S_START: begin
          issued_q   <= '0;
          captured_q <= '0;
          state_q    <= S_COMPUTE;
        end
        S_COMPUTE: if (pe_done) state_q <= S_SUMS;
        S_SUMS: begin
          if (pe_sums) issued_q <= issued_q + CW'(1);
          if (push) captured_q <= captured_q + CW'(1);
          if ((issued_q == ocount_q) && ((captured_q + CW'(push)) == ocount_q))
            state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Staging registers written in arrival order.
  always_ff @(posedge clk) begin
    if (w_fire) stage_w_q[wcnt_q[AW-1:0]] <= w_data;
    if (a_fire) stage_a_q[acnt_q[AW-1:0]] <= a_data;
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Output FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= pe_psum_o;
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: directed bench for pe_sequencer with a behavioural PE.
// A table of pass configurations is applied in a loop. Hand-written sequences
// follow for backpressure, rejected configurations and reset mid-pass.
module tb_pe_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_wcount, cfg_acount;
  logic        cfg_reuse_w, cfg_first_row, go;
  logic        w_valid, w_ready, a_valid, a_ready;
  logic [7:0]  w_data, a_data;
  logic        psin_valid, psin_ready;
  logic [19:0] psin_data;
  logic [7:0]  pe_weights, pe_acts;
  logic [19:0] pe_psum, pe_psum_o, psout_data;
  logic        pe_loadw, pe_loada, pe_start, pe_sums, pe_psum_valid, pe_done;
  logic        psout_valid, psout_ready, busy, done, cfg_err;

  always #5 clk = ~clk;

  pe_sequencer dut (
    .clk(clk), .rst(rst), .cfg_wcount(cfg_wcount), .cfg_acount(cfg_acount),
    .cfg_reuse_w(cfg_reuse_w), .cfg_first_row(cfg_first_row), .go(go),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .psin_valid(psin_valid), .psin_ready(psin_ready), .psin_data(psin_data),
    .pe_weights(pe_weights), .pe_acts(pe_acts), .pe_psum(pe_psum),
    .pe_loadw(pe_loadw), .pe_loada(pe_loada), .pe_start(pe_start), .pe_sums(pe_sums),
    .pe_psum_o(pe_psum_o), .pe_psum_valid(pe_psum_valid), .pe_done(pe_done),
    .psout_valid(psout_valid), .psout_ready(psout_ready), .psout_data(psout_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // ---------------- behavioural PE ----------------
  logic [7:0] pw [16];
  logic [7:0] pa [16];
  logic [3:0] wa, aa, sa;
  logic [2:0] dcnt;
  int         pe_w = 1;

  function automatic logic [19:0] conv(input int s);
    int acc = 0;
    for (int k = 0; k < pe_w; k++) acc += int'(pw[4'(k)]) * int'(pa[4'(s + k)]);
    return 20'(acc);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      wa <= 0; aa <= 0; sa <= 0; dcnt <= 0;
      pe_done <= 1'b0; pe_psum_valid <= 1'b0; pe_psum_o <= '0;
    end else begin
      if (pe_loadw) begin pw[wa] <= pe_weights; wa <= wa + 4'd1; end else wa <= 0;
      if (pe_loada) begin pa[aa] <= pe_acts; aa <= aa + 4'd1; end else aa <= 0;
      pe_done <= (dcnt == 3'd1);
      if (pe_start) begin dcnt <= 3'd3; sa <= 0; end
      else if (dcnt != 0) dcnt <= dcnt - 3'd1;
      pe_psum_valid <= pe_sums;
      if (pe_sums) begin
        pe_psum_o <= conv(int'(sa)) + pe_psum;
        sa <= sa + 4'd1;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, loadw_cyc = 0, loadw_runs = 0, loadw_first = 0;
  int loada_cyc = 0, loada_runs = 0, loada_first = 0, last_load = 0;
  int start_cyc = 0, start_at = 0, sums_cyc = 0, done_cnt = 0, wready_cyc = 0, hold_viol = 0;
  logic prev_lw = 1'b0, prev_la = 1'b0, hold_pend = 1'b0;
  logic [19:0] hold_data = '0;
  logic [19:0] words[$];

  always @(negedge clk) begin
    cyc++;
    if (pe_loadw) begin
      loadw_cyc++; last_load = cyc;
      if (!prev_lw) begin loadw_runs++; loadw_first = cyc; end
    end
    if (pe_loada) begin
      loada_cyc++; last_load = cyc;
      if (!prev_la) begin loada_runs++; loada_first = cyc; end
    end
    prev_lw = pe_loadw;
    prev_la = pe_loada;
    if (pe_start) begin start_cyc++; start_at = cyc; end
    if (pe_sums) sums_cyc++;
    if (done) done_cnt++;
    if (w_ready) wready_cyc++;
    if (hold_pend && (!psout_valid || psout_data != hold_data)) hold_viol++;
    hold_pend = psout_valid && !psout_ready;
    hold_data = psout_data;
    if (psout_valid && psout_ready) words.push_back(psout_data);
  end

  // ---------------- checking ----------------
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]        wcount;
    logic [7:0]        acount;
    logic              reuse;
    logic              first_row;
    logic              a_gap;
    logic [19:0]       psin;
    logic [15:0][7:0]  wv;
    logic [15:0][7:0]  av;
    logic [4:0]        exp_loadw;
    logic [4:0]        exp_loada;
    logic [1:0]        exp_n;
    logic [2:0][19:0]  ew;
  } vec_t;

  vec_t tbl [5];

  task automatic drive_w(input vec_t v);
    if (!v.reuse) begin
      for (int i = 0; i < int'(v.wcount); i++) begin
        int t = 0;
        w_valid = 1'b1; w_data = v.wv[i];
        @(negedge clk);
        while (!w_ready && t < 100) begin @(negedge clk); t++; end
        if (!w_ready) chk("w_accept", int'(w_ready), 1);
        @(posedge clk); #1;
        w_valid = 1'b0;
      end
    end
  endtask

  task automatic drive_a(input vec_t v);
    for (int i = 0; i < int'(v.acount); i++) begin
      int t = 0;
      a_valid = 1'b1; a_data = v.av[i];
      @(negedge clk);
      while (!a_ready && t < 100) begin @(negedge clk); t++; end
      if (!a_ready) chk("a_accept", int'(a_ready), 1);
      @(posedge clk); #1;
      a_valid = 1'b0;
      if (v.a_gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic start_pass(input vec_t v, input bit stall);
    pe_w          = int'(v.wcount);
    cfg_wcount    = v.wcount;
    cfg_acount    = v.acount;
    cfg_reuse_w   = v.reuse;
    cfg_first_row = v.first_row;
    psin_data     = v.psin;
    psin_valid    = !v.first_row;
    psout_ready   = !stall;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    fork
      drive_w(v);
      drive_a(v);
    join
  endtask

  task automatic run_pass(input string p, input vec_t v, input bit stall);
    int b_lw = loadw_cyc, b_lwr = loadw_runs, b_la = loada_cyc, b_lar = loada_runs;
    int b_st = start_cyc, b_sums = sums_cyc, b_done = done_cnt, b_wr = wready_cyc;
    int b_words = words.size(), b_hold = hold_viol;
    int bad = 0;
    start_pass(v, stall);
    if (stall) begin
      for (int t = 0; t < 300 && sums_cyc == b_sums; t++) @(negedge clk);
      repeat (10) @(negedge clk);
      chk({p, "_stall_issues"}, sums_cyc - b_sums, 2);
      chk({p, "_stall_words"}, words.size() - b_words, 0);
      @(posedge clk); #1 psout_ready = 1'b1;
    end
    for (int t = 0; t < 400 && done_cnt == b_done; t++) @(negedge clk);
    for (int t = 0; t < 50 && (words.size() - b_words) < int'(v.exp_n); t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({p, "_done"}, done_cnt - b_done, 1);
    chk({p, "_loadw_cycles"}, loadw_cyc - b_lw, int'(v.exp_loadw));
    chk({p, "_loada_cycles"}, loada_cyc - b_la, int'(v.exp_loada));
    chk({p, "_loada_runs"}, loada_runs - b_lar, 1);
    if (v.exp_loadw != 0) begin
      chk({p, "_loadw_runs"}, loadw_runs - b_lwr, 1);
      chk({p, "_loadw_align"}, loadw_first, loada_first);
    end else begin
      chk({p, "_w_ready_cycles"}, wready_cyc - b_wr, 0);
    end
    chk({p, "_start_cycles"}, start_cyc - b_st, 1);
    chk({p, "_gap"}, start_at - last_load, 2);
    chk({p, "_issues"}, sums_cyc - b_sums, int'(v.exp_n));
    for (int i = 0; i < int'(v.acount); i++) if (pa[i] !== v.av[i]) bad++;
    chk({p, "_act_order"}, bad, 0);
    chk({p, "_nwords"}, words.size() - b_words, int'(v.exp_n));
    for (int i = 0; i < int'(v.exp_n); i++) begin
      int got = (words.size() > b_words + i) ? int'(words[b_words + i]) : -1;
      chk($sformatf("%s_word%0d", p, i), got, int'(v.ew[i]));
    end
    chk({p, "_hold"}, hold_viol - b_hold, 0);
    chk({p, "_idle_after"}, int'(busy), 0);
    psin_valid = 1'b0;
  endtask

  task automatic bad_go(input string nm, input logic [7:0] w, input logic [7:0] a);
    cfg_wcount = w; cfg_acount = a; cfg_reuse_w = 1'b0; cfg_first_row = 1'b1;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);
    chk({nm, "_cfg_err"}, int'(cfg_err), 1);
    chk({nm, "_busy"}, int'(busy), 0);
    @(negedge clk);
    chk({nm, "_pulse"}, int'(cfg_err), 0);
    chk({nm, "_busy2"}, int'(busy), 0);
  endtask

  initial begin
    vec_t sv;
    int   b_st;
    // table: wcount acount reuse first gap psin weights acts loadw loada n words
    tbl[0] = '{8'd3, 8'd5, 1'b0, 1'b1, 1'b0, 20'd0,
               {104'd0, 8'd3, 8'd2, 8'd1}, {88'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               5'd3, 5'd5, 2'd3, {20'd26, 20'd20, 20'd14}};
    tbl[1] = '{8'd3, 8'd5, 1'b0, 1'b1, 1'b1, 20'd0,
               {104'd0, 8'd3, 8'd2, 8'd1}, {88'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5},
               5'd3, 5'd5, 2'd3, {20'd10, 20'd16, 20'd22}};
    tbl[2] = '{8'd2, 8'd4, 1'b1, 1'b1, 1'b0, 20'd0,
               {128'd0}, {96'd0, 8'd4, 8'd3, 8'd2, 8'd1},
               5'd0, 5'd4, 2'd3, {20'd11, 20'd8, 20'd5}};
    tbl[3] = '{8'd1, 8'd3, 1'b0, 1'b0, 1'b0, 20'd100,
               {120'd0, 8'd2}, {104'd0, 8'd255, 8'd0, 8'd7},
               5'd1, 5'd3, 2'd3, {20'd610, 20'd100, 20'd114}};
    tbl[4] = '{8'd16, 8'd16, 1'b0, 1'b1, 1'b0, 20'd0,
               {16{8'd1}}, {16{8'd1}},
               5'd16, 5'd16, 2'd1, {20'd0, 20'd0, 20'd16}};

    rst = 1'b1; go = 1'b0; cfg_wcount = '0; cfg_acount = '0;
    cfg_reuse_w = 1'b0; cfg_first_row = 1'b0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    psin_valid = 1'b0; psin_data = '0; psout_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'({w_ready, a_ready, psin_ready}), 0);
    chk("rst_pe_ctl", int'({pe_loadw, pe_loada, pe_start, pe_sums}), 0);
    chk("rst_outs", int'({done, cfg_err, psout_valid}), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) run_pass($sformatf("vec%0d", i), tbl[i], 1'b0);

    // Downstream stalled: only two issues may be outstanding.
    sv = tbl[0];
    sv.first_row = 1'b0;
    sv.psin      = 20'd100;
    sv.ew        = {20'd126, 20'd120, 20'd114};
    run_pass("stall", sv, 1'b1);

    bad_go("w0", 8'd0, 8'd5);
    bad_go("w6a5", 8'd6, 8'd5);
    bad_go("a17", 8'd3, 8'd17);

    // Reset while the PE is computing, then a clean pass.
    b_st = start_cyc;
    start_pass(tbl[0], 1'b0);
    for (int t = 0; t < 100 && start_cyc == b_st; t++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pe_ctl", int'({pe_loadw, pe_loada, pe_start, pe_sums}), 0);
    chk("midrst_fifo", int'(psout_valid), 0);
    chk("midrst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    run_pass("after_rst", tbl[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
